// File: rtl/sram_out_pkg.sv
// Shared types and sizes for the SRAM read-back streamer.
// Build option: SRAM_OUT_PARTIAL_EN emits a short final group instead of truncating to whole groups.
package sram_out_pkg;

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned LANES   = 4;
  localparam int unsigned MAX_LEN = 4096;
  localparam int unsigned LEN_W   = 13;
  localparam int unsigned LANE_W  = 2;

`ifdef SRAM_OUT_PARTIAL_EN
  localparam bit PARTIAL_EN = 1'b1;
`else
  localparam bit PARTIAL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Clamp to the SRAM size; without partial groups drop the remainder.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] l;
    l = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    if (!PARTIAL_EN) l[1:0] = 2'b00;
    return l;
  endfunction

endpackage

// File: rtl/sram_out_streamer_if.sv
// Control, SRAM read port and four output lanes of the streamer.
interface sram_out_streamer_if;
  import sram_out_pkg::*;

  logic              i_start;
  logic [ADDR_W-1:0] i_base_addr;
  logic [LEN_W-1:0]  i_length;
  logic              o_busy;
  logic              o_done;
  logic              o_sram_cen;
  logic              o_sram_wen;
  logic [ADDR_W-1:0] o_sram_addr;
  logic [DATA_W-1:0] i_sram_q;
  logic [DATA_W-1:0] o_out_data1, o_out_data2, o_out_data3, o_out_data4;
  logic [ADDR_W-1:0] o_out_addr1, o_out_addr2, o_out_addr3, o_out_addr4;
  logic              o_out_valid1, o_out_valid2, o_out_valid3, o_out_valid4;

  modport master (
    input  i_start, i_base_addr, i_length, i_sram_q,
    output o_busy, o_done, o_sram_cen, o_sram_wen, o_sram_addr,
           o_out_data1, o_out_data2, o_out_data3, o_out_data4,
           o_out_addr1, o_out_addr2, o_out_addr3, o_out_addr4,
           o_out_valid1, o_out_valid2, o_out_valid3, o_out_valid4
  );

  modport slave (
    output i_start, i_base_addr, i_length, i_sram_q,
    input  o_busy, o_done, o_sram_cen, o_sram_wen, o_sram_addr,
           o_out_data1, o_out_data2, o_out_data3, o_out_data4,
           o_out_addr1, o_out_addr2, o_out_addr3, o_out_addr4,
           o_out_valid1, o_out_valid2, o_out_valid3, o_out_valid4
  );
endinterface

// File: rtl/sram_lane_packer.sv
// Collects returned SRAM bytes into four lanes and emits each group as a one-cycle registered valid.
module sram_lane_packer
  import sram_out_pkg::*;
(
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_clear,
  input  logic                          i_rd_en,
  input  logic                          i_rd_last,
  input  logic [ADDR_W-1:0]             i_rd_addr,
  input  logic [DATA_W-1:0]             i_q,
  output logic [LANES-1:0][DATA_W-1:0]  o_data,
  output logic [LANES-1:0][ADDR_W-1:0]  o_addr,
  output logic [LANES-1:0]              o_valid
);

  logic                         en_q;
  logic                         last_q;
  logic [ADDR_W-1:0]            addr_q;
  logic [LANE_W-1:0]            idx_q;
  logic [LANES-1:0][DATA_W-1:0] data_r;
  logic [LANES-1:0][ADDR_W-1:0] laddr_r;
  logic                         emit_c;

  // en_q/last_q/addr_q line up with i_q, which returns one cycle after the read.
  assign emit_c = en_q && ((idx_q == LANE_W'(LANES - 1)) || (PARTIAL_EN && last_q));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      en_q    <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      idx_q   <= '0;
      data_r  <= '0;
      laddr_r <= '0;
      o_data  <= '0;
      o_addr  <= '0;
      o_valid <= '0;
    end else begin
      en_q   <= i_rd_en;
      last_q <= i_rd_last;
      addr_q <= i_rd_addr;
      if (i_clear) idx_q <= '0;
      else if (en_q) idx_q <= idx_q + LANE_W'(1);
      if (en_q) begin
        data_r[idx_q]  <= i_q;
        laddr_r[idx_q] <= addr_q;
      end
      o_data  <= '0;
      o_addr  <= '0;
      o_valid <= '0;
      // The byte arriving now completes the group, so it bypasses its lane register.
      if (emit_c) begin
        for (int i = 0; i < int'(LANES); i++) begin
          if (i <= int'(idx_q)) begin
            o_valid[i] <= 1'b1;
            if (i == int'(idx_q)) begin
              o_data[i] <= i_q;
              o_addr[i] <= addr_q;
            end else begin
              o_data[i] <= data_r[i];
              o_addr[i] <= laddr_r[i];
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/sram_out_streamer.sv
// Streams a contiguous SRAM region out on four parallel lanes, one read per cycle.
// Build option: SRAM_OUT_PARTIAL_EN (see sram_out_pkg).
module sram_out_streamer
  import sram_out_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  sram_out_streamer_if.master  bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              drain_q, drain_d;
  logic              cen_q, cen_d;
  logic              last_q, last_d;
  logic              busy_q, done_q;
  logic              clear_c;
  logic [LEN_W-1:0]  len_c;

  logic [LANES-1:0][DATA_W-1:0] lane_data;
  logic [LANES-1:0][ADDR_W-1:0] lane_addr;
  logic [LANES-1:0]             lane_valid;

  // Next state plus the read port values for the coming cycle.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    drain_d = drain_q;
    cen_d   = 1'b1;
    last_d  = 1'b0;
    clear_c = 1'b0;
    len_c   = eff_len(bus.i_length);
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          clear_c = 1'b1;
          if (len_c == '0) begin
            state_d = DONE;
          end else begin
            state_d = READ;
            cen_d   = 1'b0;
            addr_d  = bus.i_base_addr;
            rem_d   = len_c - LEN_W'(1);
            last_d  = (len_c == LEN_W'(1));
          end
        end
      end
      READ: begin
        if (rem_q == '0) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else begin
          cen_d  = 1'b0;
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - LEN_W'(1);
          last_d = (rem_q == LEN_W'(1));
        end
      end
      // Two cycles: one for the SRAM return, one for the packer's output register.
      DRAIN: begin
        if (drain_q) state_d = DONE;
        else drain_d = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      drain_q <= 1'b0;
      cen_q   <= 1'b1;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      drain_q <= drain_d;
      cen_q   <= cen_d;
      last_q  <= last_d;
      busy_q  <= (state_d == READ) || (state_d == DRAIN);
      done_q  <= (state_d == DONE);
    end
  end

  sram_lane_packer u_packer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (clear_c),
    .i_rd_en   (~cen_q),
    .i_rd_last (last_q),
    .i_rd_addr (addr_q),
    .i_q       (bus.i_sram_q),
    .o_data    (lane_data),
    .o_addr    (lane_addr),
    .o_valid   (lane_valid)
  );

  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_sram_cen   = cen_q;
  assign bus.o_sram_wen   = 1'b1;
  assign bus.o_sram_addr  = addr_q;
  assign bus.o_out_data1  = lane_data[0];
  assign bus.o_out_data2  = lane_data[1];
  assign bus.o_out_data3  = lane_data[2];
  assign bus.o_out_data4  = lane_data[3];
  assign bus.o_out_addr1  = lane_addr[0];
  assign bus.o_out_addr2  = lane_addr[1];
  assign bus.o_out_addr3  = lane_addr[2];
  assign bus.o_out_addr4  = lane_addr[3];
  assign bus.o_out_valid1 = lane_valid[0];
  assign bus.o_out_valid2 = lane_valid[1];
  assign bus.o_out_valid3 = lane_valid[2];
  assign bus.o_out_valid4 = lane_valid[3];

endmodule

// File: tb/tb_sram_out_streamer.sv
// Self-checking bench for sram_out_streamer: table of regions, SRAM model, read and group scoreboards.
module tb_sram_out_streamer;
  import sram_out_pkg::*;

`ifdef SRAM_OUT_PARTIAL_EN
  localparam bit PART = 1'b1;
`else
  localparam bit PART = 1'b0;
`endif

  typedef struct {
    int cyc;
    logic [3:0] vmask;
    logic [3:0][7:0] d;
    logic [3:0][11:0] a;
  } grp_t;

  typedef struct {
    int cyc;
    logic [11:0] a;
  } rd_t;

  typedef struct {
    int base;
    int len;
    int rst_at;
    int restart_at;
    int exp_groups;
    int exp_done;
  } case_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_out_streamer_if bus();
  sram_out_streamer dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  logic [7:0] mem [0:4095];
  always @(posedge clk) if (!bus.o_sram_cen) bus.i_sram_q <= mem[bus.o_sram_addr];

  grp_t  exp_g[$];
  rd_t   exp_r[$];
  case_t tbl[9];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int eff(input int len);
    int l;
    l = (len > 4096) ? 4096 : len;
    if (!PART) l = l & ~3;
    return l;
  endfunction

  // Expected reads and groups, as cycles relative to the start cycle.
  task automatic build_exp(input int base, input int len, input int rst_at);
    int e, n;
    grp_t g;
    rd_t r;
    e = eff(len);
    exp_g.delete();
    exp_r.delete();
    for (int k = 0; k < e; k++) begin
      r.cyc = k + 1;
      r.a   = 12'((base + k) % 4096);
      if (rst_at < 0 || r.cyc <= rst_at) exp_r.push_back(r);
    end
    for (int gi = 0; gi < (e + 3) / 4; gi++) begin
      n = (e - 4 * gi > 4) ? 4 : e - 4 * gi;
      g.cyc = 4 * gi + n + 2;
      g.vmask = '0;
      g.d = '0;
      g.a = '0;
      for (int i = 0; i < n; i++) begin
        g.vmask[i] = 1'b1;
        g.a[i] = 12'((base + 4 * gi + i) % 4096);
        g.d[i] = mem[g.a[i]];
      end
      if (rst_at < 0 || g.cyc <= rst_at) exp_g.push_back(g);
    end
  endtask

  task automatic run_case(input case_t c);
    int e, t0, rel, done_rel, ngr, busy_cnt, exp_busy, budget;
    logic [3:0] vm;
    grp_t g;
    rd_t r;
    e = eff(c.len);
    build_exp(c.base, c.len, c.rst_at);
    exp_busy = (e == 0) ? 0 : e + 2;
    if (c.rst_at >= 0 && exp_busy > c.rst_at) exp_busy = c.rst_at;
    budget = (c.rst_at >= 0) ? c.rst_at + 10 : e + 30;
    bus.i_start = 1'b1;
    bus.i_base_addr = 12'(c.base);
    bus.i_length = 13'(c.len);
    t0 = cyc;
    done_rel = -1;
    ngr = 0;
    busy_cnt = 0;
    forever begin
      tick();
      rel = cyc - t0;
      bus.i_start = (rel == c.restart_at);
      rst = (rel == c.rst_at);
      if (!bus.o_sram_cen) begin
        if (exp_r.size() == 0) chk("extra_read", 64'(rel), 64'(0));
        else begin
          r = exp_r.pop_front();
          chk("read_cycle", 64'(rel), 64'(r.cyc));
          chk("read_addr", 64'(bus.o_sram_addr), 64'(r.a));
        end
      end
      vm = {bus.o_out_valid4, bus.o_out_valid3, bus.o_out_valid2, bus.o_out_valid1};
      if (vm != 4'b0) begin
        ngr++;
        if (exp_g.size() == 0) chk("extra_group", 64'(vm), 64'(0));
        else begin
          g = exp_g.pop_front();
          chk("group_cycle", 64'(rel), 64'(g.cyc));
          chk("group_valid", 64'(vm), 64'(g.vmask));
          chk("group_data", 64'({bus.o_out_data4, bus.o_out_data3, bus.o_out_data2, bus.o_out_data1}), 64'(g.d));
          chk("group_addr", 64'({bus.o_out_addr4, bus.o_out_addr3, bus.o_out_addr2, bus.o_out_addr1}), 64'(g.a));
        end
      end
      if (bus.o_busy) busy_cnt++;
      if (bus.o_done) begin
        if (done_rel < 0) done_rel = rel;
        else chk("extra_done", 64'(rel), 64'(0));
      end
      if (c.rst_at >= 0 && rel == c.rst_at + 1) begin
        chk("abort_outputs", 64'({vm, bus.o_busy, bus.o_done, bus.o_out_data1, bus.o_out_data2,
              bus.o_out_data3, bus.o_out_data4, bus.o_out_addr1 | bus.o_out_addr2 | bus.o_out_addr3 | bus.o_out_addr4}), 64'(0));
        chk("abort_cen", 64'(bus.o_sram_cen), 64'(1));
      end
      if (done_rel >= 0 && c.rst_at < 0) break;
      if (rel >= budget) break;
    end
    chk("done_cycle", 64'(done_rel), 64'(c.exp_done));
    chk("group_count", 64'(ngr), 64'(c.exp_groups));
    chk("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
    chk("missing_groups", 64'(exp_g.size()), 64'(0));
    chk("missing_reads", 64'(exp_r.size()), 64'(0));
    chk("wen_tied", 64'(bus.o_sram_wen), 64'(1));
    tick();
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_base_addr = '0;
    bus.i_length = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + i / 256);

    //            base  len   rst restart groups done
    tbl[0] = '{0,    8,    -1, -1,  2,    11};
    tbl[1] = '{4094, 4,    -1, -1,  1,    7};
    tbl[2] = '{0,    0,    -1, -1,  0,    1};
    tbl[3] = '{100,  6,    -1, -1,  PART ? 2 : 1,  PART ? 9 : 7};
    tbl[4] = '{10,   3,    -1, -1,  PART ? 1 : 0,  PART ? 6 : 1};
    tbl[5] = '{0,    4096, 4,  -1,  0,    -1};
    tbl[6] = '{200,  16,   -1, 3,   4,    19};
    tbl[7] = '{4000, 5000, -1, -1,  1024, 4099};
    tbl[8] = '{5,    13,   -1, -1,  PART ? 4 : 3,  PART ? 16 : 15};

    // Reset state
    repeat (3) tick();
    chk("rst_busy", 64'(bus.o_busy), 64'(0));
    chk("rst_done", 64'(bus.o_done), 64'(0));
    chk("rst_cen", 64'(bus.o_sram_cen), 64'(1));
    chk("rst_wen", 64'(bus.o_sram_wen), 64'(1));
    chk("rst_addr", 64'(bus.o_sram_addr), 64'(0));
    chk("rst_lanes", 64'({bus.o_out_valid1, bus.o_out_valid2, bus.o_out_valid3, bus.o_out_valid4,
          bus.o_out_data1, bus.o_out_data2, bus.o_out_data3, bus.o_out_data4,
          bus.o_out_addr1 | bus.o_out_addr2 | bus.o_out_addr3 | bus.o_out_addr4}), 64'(0));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) run_case(tbl[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_out_streamer.md
# sram_out_streamer

Reads a contiguous pixel region back out of the 4096x8 single-port image SRAM and presents it on the core's four parallel output lanes (data, address, valid per lane). It is the read-side counterpart of the input loader, which packs 32-bit words into SRAM bytes. This block unpacks SRAM bytes into 4-lane output groups. It owns the SRAM port only while busy; the core's arbiter selects it after the load and decode phases.

## Interface
- ADDR_W, 12, SRAM/output address width
- DATA_W, 8, pixel width
- LANES, 4, output lanes per group (fixed at 4; other values unsupported)
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle request; sampled only in IDLE
- i_base_addr  in  12  first SRAM address of region
- i_length  in  13  pixel count, 0..4096; values >4096 clamp to 4096
- o_busy  out  1  high from first read cycle through last group-valid cycle
- o_done  out  1  one-cycle pulse at completion
- o_sram_cen  out  1  active-low chip enable
- o_sram_wen  out  1  tied 1 (read-only)
- o_sram_addr  out  12  read address
- i_sram_q  in  8  SRAM read data, valid the cycle after address is issued
- o_out_data1..4  out  8 each  lane pixel
- o_out_addr1..4  out  12 each  lane pixel address
- o_out_valid1..4  out  1 each  lane valid

## Operation
- FSM: IDLE -> READ -> DRAIN -> DONE -> IDLE.
- IDLE: i_start latches base and clamped length. Length 0 goes straight to DONE; otherwise go to READ.
- READ: issue one read per cycle at base+offset, with offset 0..len-1. Address arithmetic is mod 4096, so base 4094, len 4 reads 4094, 4095, 0, 1. After the final address, go to DRAIN.
- Lane packer: returned byte k goes to lane (k mod 4)+1 with address base+k mod 4096. After the 4th byte of a group, all four lanes go valid together for exactly one cycle.
- DRAIN: wait for the outstanding read and emit the last group, then go to DONE.
- DONE: o_done pulses for one cycle, then IDLE.
- i_start while not IDLE: ignored, no queuing.
- Invalid lanes drive data 0, addr 0.
- No output backpressure. The consumer must accept every valid group.

## Timing
- Reset values: all o_out_* 0, o_busy 0, o_done 0, o_sram_cen 1, o_sram_wen 1, o_sram_addr 0. FSM returns to IDLE.
- Reset mid-operation: aborts at the next edge. No further valids and no o_done.
- o_sram_cen is 0 only in READ cycles.
- Cycle references (i_start at cycle 0):
  - reads are issued in cycles 1..len;
  - group g (0-based) is valid in cycle 4g+6;
  - a full-length region of N=len/4 groups has its last group in cycle 4N+2 and o_done in cycle 4N+3;
  - len=0 gives o_done in cycle 1, with o_busy never high.
- Throughput: one group every 4 cycles, back-to-back with no bubbles.
- Earliest next i_start: the cycle after o_done.

## Configuration
- SRAM_OUT_PARTIAL_EN defined: if len mod 4 = r ≠ 0, the final group has only lanes 1..r valid. It appears 2 cycles after its last read, and o_done follows the cycle after that.
- Undefined: i_length[1:0] is ignored (length truncated to a multiple of 4), so a remainder is never read. A length of 1..3 behaves as length 0.

## Structure
- Package sram_out_pkg holds:
  - ADDR_W, DATA_W, LANES and MAX_LEN=4096;
  - the FSM state enum (IDLE, READ, DRAIN, DONE).
- One sub-module, sram_lane_packer: captures i_sram_q into lane registers using a 2-bit lane index plus a delayed read-valid, and emits registered valid groups. The top level holds the FSM, offset counter and address generation.

## Test plan
- Reset, then base=0, len=8 with SRAM[i]=i -> group 0 in cycle 6: data 0,1,2,3, addr 0..3, all valids 1. Group 1 in cycle 10: data 4..7. o_done in cycle 11.
- base=4094, len=4 -> reads 4094, 4095, 0, 1. Lane addrs 4094, 4095, 0, 1. Single group in cycle 6.
- len=0 -> o_done in cycle 1. No CEN low, no valids, o_busy stays 0.
- len=6 with SRAM_OUT_PARTIAL_EN -> group 2 has only lanes 1,2 valid (data SRAM[4], SRAM[5]). Without the macro, one group only and o_done in cycle 7.
- i_rst asserted at cycle 4 of a len=4096 run -> all outputs 0 from the next cycle, no o_done. A new i_start after reset runs correctly.
- i_start pulsed in cycles 0 and 3 -> the second pulse is ignored and exactly len/4 groups are emitted.
